// File: rtl/add_nbit_pipe.sv
// Segmented ripple-carry adder/subtractor: one SW-bit slice per stage, carry registered
// between stages, with unconsumed operand bits and finished result bits travelling alongside.
module add_nbit_pipe #(
  parameter int unsigned LENGTH = 16,
  parameter int unsigned SEG    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              sub,
  input  logic [LENGTH-1:0] A,
  input  logic [LENGTH-1:0] B,
  input  logic              Cin,
  output logic              out_valid,
  output logic [LENGTH-1:0] Y,
  output logic              Cout,
  output logic              Ovf
);

  localparam int unsigned SW  = LENGTH / SEG;
  localparam int unsigned MSB = LENGTH - 1;

  logic              w_last_v;
  logic              w_last_c;
  logic              w_last_ovf;
  logic [LENGTH-1:0] w_last_y;

  for (genvar k = 0; k < SEG; k++) begin : g_seg
    localparam int unsigned LO = k * SW;

    logic              w_vi;
    logic              w_ci;
    // Low bits already hold finished result slices; high bits still hold operand A.
    logic [LENGTH-1:0] w_xi;
    logic [LENGTH-1:0] w_xo;
    logic [MSB:LO]     w_bi;
    logic [SW:0]       w_sum;

    if (k == 0) begin : g_in
      // sub/Cin are folded into Be and the first carry, so they travel with the operation.
      assign w_vi = in_valid;
      assign w_ci = sub ? 1'b1 : Cin;
      assign w_xi = A;
      assign w_bi = sub ? ~B : B;
    end else begin : g_link
      assign w_vi = g_seg[k-1].g_reg.r_v;
      assign w_ci = g_seg[k-1].g_reg.r_c;
      assign w_xi = g_seg[k-1].g_reg.r_x;
      assign w_bi = g_seg[k-1].g_reg.r_b;
    end

    assign w_sum = {1'b0, w_xi[LO +: SW]} + {1'b0, w_bi[LO +: SW]} + {{SW{1'b0}}, w_ci};

    always_comb begin
      w_xo            = w_xi;
      w_xo[LO +: SW]  = w_sum[SW-1:0];
    end

    if (k < SEG - 1) begin : g_reg
      logic                 r_v;
      logic                 r_c;
      logic [LENGTH-1:0]    r_x;
      logic [MSB:LO+SW]     r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v <= 1'b0;
          r_c <= 1'b0;
          r_x <= '0;
          r_b <= '0;
        end else begin
          r_v <= w_vi;
          r_c <= w_sum[SW];
          r_x <= w_xo;
          r_b <= w_bi[MSB:LO+SW];
        end
      end
    end

    if (k == SEG - 1) begin : g_last
      // The MSB of A and Be is only consumed here, so overflow is resolved in this slice.
      assign w_last_v   = w_vi;
      assign w_last_c   = w_sum[SW];
      assign w_last_y   = w_xo;
      assign w_last_ovf = (w_xi[MSB] == w_bi[MSB]) && (w_xo[MSB] != w_xi[MSB]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Y         <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      out_valid <= w_last_v;
      if (w_last_v) begin
        Y    <= w_last_y;
        Cout <= w_last_c;
        Ovf  <= w_last_ovf;
      end
    end
  end

endmodule

// File: tb/tb_add_nbit_pipe.sv
// Directed bench for add_nbit_pipe: a 16-bit/4-segment instance driven from a vector table,
// plus reset-abort and first-edge sequences, and an 8-bit single-segment instance.
module tb_add_nbit_pipe;

  localparam int unsigned SEG = 4;
  localparam int NV = 16;

  typedef struct {
    logic        v;
    logic        s;
    logic        c;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        co;
    logic        ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic [15:0] y;
  logic        cout;
  logic        ovf;

  logic        v8 = 1'b0;
  logic        s8 = 1'b0;
  logic        c8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ov8_valid;
  logic [7:0]  y8;
  logic        co8;
  logic        of8;

  int total = 0;
  int bad = 0;

  vec_t        tv[NV];
  logic [15:0] held_y;
  logic        held_co;
  logic        held_ov;

  add_nbit_pipe #(.LENGTH(16), .SEG(SEG)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sub       (sub),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .out_valid (out_valid),
    .Y         (y),
    .Cout      (cout),
    .Ovf       (ovf)
  );

  add_nbit_pipe #(.LENGTH(8), .SEG(1)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8),
    .sub       (s8),
    .A         (a8),
    .B         (b8),
    .Cin       (c8),
    .out_valid (ov8_valid),
    .Y         (y8),
    .Cout      (co8),
    .Ovf       (of8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic v, input logic s, input logic c,
                         input logic [15:0] ai, input logic [15:0] bi, input logic [15:0] yi,
                         input logic co, input logic ov);
    tv[i].v  = v;
    tv[i].s  = s;
    tv[i].c  = c;
    tv[i].a  = ai;
    tv[i].b  = bi;
    tv[i].y  = yi;
    tv[i].co = co;
    tv[i].ov = ov;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    sub      = 1'b0;
    cin      = 1'b0;
    a        = '0;
    b        = '0;
  endtask

  initial begin
    //         v     s     c     A         B         Y         Cout  Ovf
    set_vec(0,  1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0);
    set_vec(1,  1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
    set_vec(2,  1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    set_vec(3,  1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0);
    set_vec(4,  1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    set_vec(5,  1'b1, 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    set_vec(6,  1'b1, 1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    set_vec(7,  1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
    set_vec(8,  1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    set_vec(9,  1'b1, 1'b0, 1'b0, 16'h0002, 16'h0002, 16'h0004, 1'b0, 1'b0);
    set_vec(10, 1'b1, 1'b0, 1'b0, 16'hC3A5, 16'h5C5B, 16'h2000, 1'b1, 1'b0);
    set_vec(11, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0);
    set_vec(12, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h1234, 16'h2469, 1'b0, 1'b0);
    set_vec(13, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    set_vec(14, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    set_vec(15, 1'b1, 1'b0, 1'b0, 16'h4001, 16'h4000, 16'h8001, 1'b0, 1'b1);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_valid8", 32'(ov8_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    held_y  = '0;
    held_co = 1'b0;
    held_ov = 1'b0;

    // Table stream: vector c is sampled at edge c and exits after edge c+SEG-1
    for (int c = 0; c < NV + int'(SEG); c++) begin
      @(negedge clk);
      if (c < NV) begin
        in_valid = tv[c].v;
        sub      = tv[c].s;
        cin      = tv[c].c;
        a        = tv[c].a;
        b        = tv[c].b;
      end else begin
        drive_idle();
      end
      @(posedge clk);
      #1;
      begin
        int idx;
        idx = c - (int'(SEG) - 1);
        if (idx < 0) begin
          chk($sformatf("fill_valid_c%0d", c), 32'(out_valid), 32'd0);
        end else if (idx < NV) begin
          chk($sformatf("valid_v%0d", idx), 32'(out_valid), 32'(tv[idx].v));
          if (tv[idx].v) begin
            held_y  = tv[idx].y;
            held_co = tv[idx].co;
            held_ov = tv[idx].ov;
          end
          chk($sformatf("y_v%0d", idx), 32'(y), 32'(held_y));
          chk($sformatf("cout_v%0d", idx), 32'(cout), 32'(held_co));
          chk($sformatf("ovf_v%0d", idx), 32'(ovf), 32'(held_ov));
        end else begin
          chk($sformatf("drain_valid_c%0d", c), 32'(out_valid), 32'd0);
          chk($sformatf("drain_y_c%0d", c), 32'(y), 32'(held_y));
        end
      end
    end

    // Two ops in flight, reset pulsed two cycles later: nothing may ever emerge
    @(negedge clk);
    in_valid = 1'b1; a = 16'h0101; b = 16'h0202; sub = 1'b0; cin = 1'b0;
    @(negedge clk);
    a = 16'h0303; b = 16'h0404;
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #2;
    chk("abort_pre_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release samples a new op
    in_valid = 1'b1; a = 16'h0003; b = 16'h0004; sub = 1'b0; cin = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (c == int'(SEG) - 1) begin
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_y", 32'(y), 32'h0007);
        chk("post_rst_cout", 32'(cout), 32'd0);
      end else begin
        chk($sformatf("post_rst_idle_c%0d", c), 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      drive_idle();
    end

    // LENGTH=8, SEG=1 instance
    @(negedge clk);
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; s8 = 1'b0;
    @(posedge clk);
    #1;
    chk("seg1_valid", 32'(ov8_valid), 32'd1);
    chk("seg1_y", 32'(y8), 32'h00);
    chk("seg1_cout", 32'(co8), 32'd1);
    chk("seg1_ovf", 32'(of8), 32'd0);
    @(negedge clk);
    v8 = 1'b0; a8 = 8'h7F; b8 = 8'h01; s8 = 1'b0;
    @(posedge clk);
    #1;
    chk("seg1_bubble_valid", 32'(ov8_valid), 32'd0);
    chk("seg1_hold_cout", 32'(co8), 32'd1);
    @(negedge clk);
    v8 = 1'b1; a8 = 8'h80; b8 = 8'h01; s8 = 1'b1; c8 = 1'b0;
    @(posedge clk);
    #1;
    chk("seg1_sub_y", 32'(y8), 32'h7F);
    chk("seg1_sub_ovf", 32'(of8), 32'd1);
    @(negedge clk);
    v8 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
